// File: rtl/dma_periph_pkg.sv
// dma_periph_pkg: shared state/direction types and default bus width for dma_periph_port
package dma_periph_pkg;
  localparam int DW_DEFAULT = 8;
  typedef enum logic [2:0] {IDLE, ARM, WAIT, ACK, DONE} state_t;
  typedef enum logic {DEV2MEM, MEM2DEV} dir_t;
endpackage

// File: rtl/dma_periph_fifo.sv
// dma_periph_fifo: synchronous FIFO with full/empty flags; head reads 0 when empty
module dma_periph_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign push = wr && !full;
  assign pop = rd && !empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/dma_periph_port.sv
// dma_periph_port: peripheral DMA handshake port with TX/RX FIFOs; WAIT state built only with DMA_PERIPH_WAIT_EN
module dma_periph_port
  import dma_periph_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int DEPTH = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          IOR,
  input  logic          IOW,
  output logic          READY,
  output logic          EOP,
  output logic [DW-1:0] DB_OUT,
  output logic          DB_OE,
  input  logic [DW-1:0] DB_IN,
  input  logic          start,
  input  logic          dir,
  input  logic [15:0]   block_len,
  input  logic          abort,
  output logic          done,
  input  logic [DW-1:0] tx_wdata,
  input  logic          tx_wr,
  output logic          tx_full,
  output logic [DW-1:0] rx_rdata,
  input  logic          rx_rd,
  output logic          rx_empty
);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_range
    $error("WAIT_CYCLES must be 0..15");
  end
  state_t state, state_n;
  dir_t dir_q;
  logic [15:0] count;
  logic eop_q, strobe, data_ok, rdy, skip_wait, commit, tx_empty, rx_full;
  logic [DW-1:0] tx_head;
  assign strobe = dir_q == MEM2DEV ? IOW : IOR;
  assign data_ok = dir_q == DEV2MEM ? !tx_empty : !rx_full;
`ifdef DMA_PERIPH_WAIT_EN
  logic [3:0] wcnt;
  assign rdy = state != WAIT || wcnt == 4'(WAIT_CYCLES);
  assign skip_wait = WAIT_CYCLES == 0;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) wcnt <= '0;
    else wcnt <= state == WAIT && state_n == WAIT ? wcnt + 4'd1 : 4'd0;
`else
  assign rdy = 1'b1;
  assign skip_wait = 1'b1;
`endif
  // entering ACK is the commit edge; abort overrides any pending commit
  always_comb begin
    state_n = state;
    commit = 1'b0;
    case (state)
      IDLE: if (start) state_n = block_len == '0 ? DONE : ARM;
      ARM: if (strobe && DACK && data_ok) begin
        state_n = skip_wait ? ACK : WAIT;
        commit = skip_wait;
      end
`ifdef DMA_PERIPH_WAIT_EN
      WAIT: if (!(strobe && DACK)) state_n = ARM;
        else if (rdy) begin
          state_n = ACK;
          commit = 1'b1;
        end
`endif
      ACK: if (!strobe) state_n = count == '0 ? DONE : ARM;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      commit = 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      dir_q <= DEV2MEM;
      count <= '0;
      eop_q <= 1'b0;
    end else begin
      state <= state_n;
      eop_q <= (abort && state != IDLE) || (commit && count == 16'd1);
      if (state == IDLE && start) begin
        dir_q <= dir_t'(dir);
        count <= block_len;
      end else if (commit) count <= count - 16'd1;
    end
  assign READY = rdy;
  assign EOP = eop_q;
  assign done = state == DONE;
  assign DREQ = state == ARM ? data_ok : state == WAIT ? 1'b1 : state == ACK ? count != '0 : 1'b0;
  assign DB_OE = DACK && IOR && dir_q == DEV2MEM && (state == WAIT || state == ACK);
  assign DB_OUT = DB_OE ? tx_head : '0;
  dma_periph_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk(CLK), .rst_n(RESET_N), .wr(tx_wr), .wdata(tx_wdata),
    .rd(commit && dir_q == DEV2MEM), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );
  dma_periph_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk(CLK), .rst_n(RESET_N), .wr(commit && dir_q == MEM2DEV), .wdata(DB_IN),
    .rd(rx_rd), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );
endmodule

// File: tb/tb_dma_periph_port.sv
// tb_dma_periph_port: directed + randomized check of dma_periph_port against a queue-based transfer model
module tb_dma_periph_port;
  localparam int DW = 8;
  localparam int DEPTH = 4;
`ifdef DMA_PERIPH_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  logic CLK = 0, RESET_N = 0, DACK = 0, IOR = 0, IOW = 0, start = 0, dir = 0, abort = 0;
  logic tx_wr = 0, rx_rd = 0;
  logic [DW-1:0] DB_IN = 0, tx_wdata = 0;
  logic [15:0] block_len = 0;
  logic DREQ, READY, EOP, DB_OE, done, tx_full, rx_empty;
  logic [DW-1:0] DB_OUT, rx_rdata;
  always #5 CLK = ~CLK;

  dma_periph_port #(.DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK), .IOR(IOR), .IOW(IOW),
    .READY(READY), .EOP(EOP), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(DB_IN),
    .start(start), .dir(dir), .block_len(block_len), .abort(abort), .done(done),
    .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full), .rx_rdata(rx_rdata),
    .rx_rd(rx_rd), .rx_empty(rx_empty)
  );

  int total = 0, bad = 0;
  int eop_cnt = 0, rdy_lo = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // transfer model: FIFO contents as queues, the transfer as remaining count plus phase flags
  logic [DW-1:0] txq[$], rxq[$];
  bit busy, waiting, holding, closing, meop, mdir;
  int rem, wleft;

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    busy = 0; waiting = 0; holding = 0; closing = 0; meop = 0; mdir = 0;
    rem = 0; wleft = 0;
  endtask

  task automatic model_compare();
    bit strb, dok, armed, e_oe;
    strb = mdir ? IOW : IOR;
    dok = mdir ? rxq.size() < DEPTH : txq.size() > 0;
    armed = busy && !waiting && !holding;
    e_oe = DACK && IOR && !mdir && (waiting || holding);
    chk("m_dreq", DREQ, armed ? dok : waiting ? 1 : holding ? rem != 0 : 0);
    chk("m_ready", READY, !(waiting && wleft != 0));
    chk("m_eop", EOP, meop);
    chk("m_done", done, closing);
    chk("m_db_oe", DB_OE, e_oe);
    chk("m_db_out", DB_OUT, (e_oe && txq.size() > 0) ? txq[0] : 0);
    chk("m_tx_full", tx_full, txq.size() == DEPTH);
    chk("m_rx_empty", rx_empty, rxq.size() == 0);
    chk("m_rx_rdata", rx_rdata, rxq.size() > 0 ? rxq[0] : 0);
  endtask

  task automatic model_step();
    bit strb, dok, c, e, txp, rxp, rxpop;
    strb = mdir ? IOW : IOR;
    dok = mdir ? rxq.size() < DEPTH : txq.size() > 0;
    c = 0; e = 0;
    txp = tx_wr && txq.size() < DEPTH;
    rxpop = rx_rd && rxq.size() > 0;
    if (!busy && !closing) begin
      if (start) begin
        mdir = dir;
        rem = block_len;
        if (block_len == 0) closing = 1; else busy = 1;
      end
    end else if (abort) begin
      e = 1; busy = 0; closing = 0; waiting = 0; holding = 0;
    end else if (closing) closing = 0;
    else if (holding) begin
      if (!strb) begin
        holding = 0;
        if (rem == 0) begin busy = 0; closing = 1; end
      end
    end else if (waiting) begin
      if (!(strb && DACK)) waiting = 0;
      else if (wleft == 0) begin waiting = 0; holding = 1; c = 1; end
      else wleft--;
    end else if (strb && DACK && dok) begin
      if (W == 0) begin holding = 1; c = 1; end
      else begin waiting = 1; wleft = W; end
    end
    if (c) begin
      rem--;
      if (rem == 0) e = 1;
    end
    meop = e;
    rxp = c && mdir && rxq.size() < DEPTH;
    if (c && !mdir && txq.size() > 0) void'(txq.pop_front());
    if (txp) txq.push_back(tx_wdata);
    if (rxpop) void'(rxq.pop_front());
    if (rxp) rxq.push_back(DB_IN);
  endtask

  always @(negedge CLK) begin
    if (!RESET_N) model_reset();
    model_compare();
    if (RESET_N) model_step();
    if (EOP) eop_cnt++;
    if (!READY) rdy_lo++;
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] v);
    tx_wdata = v; tx_wr = 1; step(); tx_wr = 0;
  endtask

  task automatic go(input logic d, input int len);
    dir = d; block_len = 16'(len); start = 1; step(); start = 0;
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (!DREQ && n < 60) begin step(); n++; end
    chk("dreq_wait", DREQ, 1);
  endtask

  task automatic xfer(input bit w, input logic [7:0] d, input int hold, output logic [7:0] first);
    bit got = 0;
    first = '0;
    wait_dreq();
    DB_IN = d; DACK = 1; IOR = !w; IOW = w;
    repeat (hold) begin
      #1;
      if (DB_OE && !got) begin got = 1; first = DB_OUT; end
      step();
    end
    IOR = 0; IOW = 0; step(); DACK = 0;
  endtask

  initial begin
    logic [7:0] a33 [3];
    logic [7:0] f, exp_f;
    int e0, d0, r0;
    a33 = '{8'hA1, 8'hA2, 8'hA3};
    repeat (2) step();
    #1;
    chk("rst_ready", READY, 1);
    chk("rst_dreq", DREQ, 0);
    chk("rst_eop", EOP, 0);
    chk("rst_done", done, 0);
    chk("rst_db_oe", DB_OE, 0);
    chk("rst_db_out", DB_OUT, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    RESET_N = 1;
    step();
    // device-to-memory block of three
    e0 = eop_cnt; d0 = done_cnt; r0 = rdy_lo;
    for (int k = 0; k < 3; k++) push_tx(a33[k]);
    go(0, 3);
    for (int k = 0; k < 3; k++) begin
      xfer(0, 8'h00, 4, f);
      exp_f = W > 0 ? a33[k] : (k < 2 ? a33[k+1] : 8'h00);
      chk("r33_db_out", f, exp_f);
    end
    #1 chk("r33_done", done, 1);
    step();
    chk("r33_eop_pulses", eop_cnt - e0, 1);
    chk("r33_done_pulses", done_cnt - d0, 1);
    chk("r33_ready_low", rdy_lo - r0, 3 * W);
    go(0, 1);
    #1 chk("r33_tx_empty", DREQ, 0);
    abort = 1; step(); abort = 0; step();
    // memory-to-device block of two
    go(1, 2);
    xfer(1, 8'h5C, W + 2, f);
    xfer(1, 8'hC5, W + 2, f);
    #1 chk("r34_dreq_end", DREQ, 0);
    step();
    chk("r34_rx0", rx_rdata, 8'h5C);
    rx_rd = 1; step(); rx_rd = 0;
    #1 chk("r34_rx1", rx_rdata, 8'hC5);
    rx_rd = 1; step(); rx_rd = 0;
    #1 chk("r34_rx_empty", rx_empty, 1);
    // RX full blocks the request
    go(1, 4);
    for (int k = 0; k < 4; k++) xfer(1, 8'(8'h10 + k), W + 2, f);
    step();
    go(1, 1);
    repeat (3) begin #1 chk("r35_dreq_full", DREQ, 0); step(); end
    rx_rd = 1; step(); rx_rd = 0;
    #1 chk("r35_dreq_after", DREQ, 1);
    xfer(1, 8'h77, W + 2, f);
    step();
    repeat (3) begin rx_rd = 1; step(); end
    rx_rd = 0;
    // abort on the second of four transfers
    for (int k = 0; k < 4; k++) push_tx(8'(8'hB0 + k));
    #1 chk("r36_tx_full", tx_full, 1);
    go(0, 4);
    xfer(0, 8'h00, W + 2, f);
    wait_dreq();
    if (W > 0) begin DACK = 1; IOR = 1; step(); end
    abort = 1; step(); abort = 0; IOR = 0; DACK = 0;
    #1 chk("r36_eop", EOP, 1);
    chk("r36_dreq", DREQ, 0);
    step();
    #1 chk("r36_eop_end", EOP, 0);
    chk("r36_tx_three", tx_full, 0);
    push_tx(8'hB4);
    #1 chk("r36_tx_refull", tx_full, 1);
    // DACK withdrawn during the wait leaves the entry in place
    go(0, 1);
`ifdef DMA_PERIPH_WAIT_EN
    wait_dreq();
    DACK = 1; IOR = 1; step();
    DACK = 0; step();
    #1 chk("r37_dreq", DREQ, 1);
    chk("r37_ready", READY, 1);
    IOR = 0; step();
`endif
    xfer(0, 8'h00, W + 2, f);
    chk("r37_same_entry", f, W > 0 ? 8'hB1 : 8'hB2);
    step();
    #1 chk("r37_tx_pop", tx_full, 0);
    // reset in the middle of ACK
    chk("r38_rx_before", rx_empty, 0);
    go(0, 2);
    wait_dreq();
    DACK = 1; IOR = 1;
    repeat (W + 2) step();
    #1 chk("r38_oe_before", DB_OE, 1);
    RESET_N = 0;
    #1;
    chk("r38_dreq", DREQ, 0);
    chk("r38_ready", READY, 1);
    chk("r38_eop", EOP, 0);
    chk("r38_done", done, 0);
    chk("r38_db_oe", DB_OE, 0);
    chk("r38_db_out", DB_OUT, 0);
    chk("r38_rx_empty", rx_empty, 1);
    chk("r38_tx_full", tx_full, 0);
    IOR = 0; DACK = 0;
    step(); step();
    RESET_N = 1;
    step();
    go(0, 1);
    #1 chk("r38_tx_empty", DREQ, 0);
    abort = 1; step(); abort = 0; step();
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      RESET_N = $urandom_range(0, 599) != 0;
      start = $urandom_range(0, 5) == 0;
      dir = 1'($urandom_range(0, 1));
      block_len = 16'($urandom_range(0, 4));
      abort = $urandom_range(0, 49) == 0;
      DACK = $urandom_range(0, 7) != 0;
      IOR = $urandom_range(0, 2) != 0;
      IOW = $urandom_range(0, 2) != 0;
      DB_IN = 8'($urandom);
      tx_wr = $urandom_range(0, 2) == 0;
      tx_wdata = 8'($urandom);
      rx_rd = $urandom_range(0, 3) == 0;
      step();
    end
    RESET_N = 1; start = 0; abort = 0; DACK = 0; IOR = 0; IOW = 0; tx_wr = 0; rx_rd = 0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_periph_port.md
DMA_PERIPH_PORT -- requirements
Module: dma_periph_port

Interface
REQ-001 SHALL have parameter DW, default 8, data-bus width.
REQ-002 SHALL have parameter DEPTH, default 4, entries per FIFO, power of two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, READY-low cycles per strobe, range 0..15.
REQ-004 SHALL have port CLK  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports DREQ out 1 (service request); DACK in 1 (acknowledge); IOR in 1 (device-to-memory read strobe); IOW in 1 (memory-to-device write strobe).
REQ-007 SHALL have ports READY out 1 (wait control); EOP out 1 (end-of-process pulse).
REQ-008 SHALL have ports DB_OUT out DW (read data); DB_OE out 1 (drive enable); DB_IN in DW (write data).
REQ-009 SHALL have local ports start in 1; dir in 1 (0 = device-to-memory, 1 = memory-to-device); block_len in 16; abort in 1; done out 1.
REQ-010 SHALL have local FIFO ports tx_wdata in DW, tx_wr in 1, tx_full out 1, rx_rdata out DW, rx_rd in 1, rx_empty out 1.

Function
REQ-011 SHALL implement states IDLE, ARM, WAIT, ACK, DONE.
REQ-012 In IDLE, start SHALL latch dir and load count = block_len, then go to ARM; block_len 0 SHALL go directly to DONE.
REQ-013 In ARM, DREQ SHALL be 1 while data is ready: TX not empty for dir 0, RX not full for dir 1.
REQ-014 In ARM, the active strobe (IOR for dir 0, IOW for dir 1) with DACK=1 SHALL go to WAIT, or to ACK when WAIT_CYCLES=0.
REQ-015 In WAIT, READY SHALL be 0 for exactly WAIT_CYCLES cycles, then state goes to ACK; READY SHALL be 1 in all other states.
REQ-016 Commit SHALL occur on the ACK-entry edge where strobe, DACK and READY are all 1: pop TX for dir 0, push DB_IN to RX for dir 1, count decrements.
REQ-017 Only one commit SHALL occur per strobe; ACK SHALL hold until the strobe is low.
REQ-018 On strobe low in ACK, the FSM SHALL go to DONE if count is 0, otherwise to ARM.
REQ-019 EOP SHALL pulse 1 for one cycle on the edge of the final commit.
REQ-020 DB_OE and DB_OUT SHALL be combinational: DB_OE = DACK & IOR & dir==0 & state in {WAIT, ACK}; DB_OUT = TX head when DB_OE=1, else 0.
REQ-021 DREQ SHALL stay 1 through WAIT and ACK until the final commit; it SHALL be 0 in IDLE and DONE.
REQ-022 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-023 Abort in any non-IDLE state SHALL pulse EOP for one cycle and go to IDLE; FIFO contents SHALL be preserved.
REQ-024 If DACK drops in WAIT before commit, the FSM SHALL return to ARM without a commit.
REQ-025 tx_wr when full and rx_rd when empty SHALL be ignored; local push/pop SHALL be allowed concurrently with bus commits.
REQ-026 start outside IDLE SHALL be ignored.

Reset
REQ-027 RESET_N low SHALL asynchronously force IDLE, count 0, wait counter 0, both FIFOs empty, DREQ 0, EOP 0, done 0, READY 1, DB_OE 0, DB_OUT 0.
REQ-028 Reset mid-transfer SHALL discard the transfer; no commit SHALL occur on the release edge.

Configuration
REQ-029 With macro DMA_PERIPH_WAIT_EN defined, the WAIT state and WAIT_CYCLES SHALL operate as specified.
REQ-030 Without DMA_PERIPH_WAIT_EN, WAIT SHALL be removed, READY SHALL be constant 1, and ARM SHALL go directly to ACK.

Structure
REQ-031 Package dma_periph_pkg SHALL hold the state enum, the direction enum (DEV2MEM, MEM2DEV) and the default DW.
REQ-032 Both FIFOs SHALL be instances of sub-module dma_periph_fifo (synchronous, DEPTH entries, full/empty flags, async active-low reset).

Verification
REQ-033 dir=0, block_len=3, TX preloaded A1,A2,A3, each IOR held 4 cycles -> DB_OUT shows A1,A2,A3 in order; READY low 2 cycles per strobe; EOP pulse on third commit; done one cycle later; tx_empty=1.
REQ-034 dir=1, block_len=2, DB_IN 5C then C5 on IOW -> rx_rdata pops 5C then C5; DREQ 0 after second commit.
REQ-035 dir=1 with RX full (4 entries), start -> DREQ stays 0 until one rx_rd, then DREQ 1 next cycle.
REQ-036 abort during WAIT of the second of 4 transfers -> EOP one cycle; IDLE; exactly 1 commit; count not exposed; TX retains 3 entries.
REQ-037 DACK dropped during WAIT -> no pop; state ARM; DREQ still 1; next full strobe commits the same entry.
REQ-038 RESET_N pulsed low mid-ACK -> all outputs at reset values within the same cycle; tx_empty=1 and rx_empty=1.
